// File: rtl/redux_sequencer_if.sv
// Memory-side handshake bundle for the redux sequencer: instruction fetch and data access req/ack.
interface redux_sequencer_if;
    logic imem_req;
    logic imem_ack;
    logic ir_en;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req, ir_en, dmem_req, dmem_we,
        input  imem_ack, dmem_ack
    );

    modport slave (
        input  imem_req, ir_en, dmem_req, dmem_we,
        output imem_ack, dmem_ack
    );
endinterface

// File: rtl/redux_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB controller for the 8-bit redux datapath.
// Optional single-step input is enabled by defining REDUX_SEQ_STEP_EN.
module redux_sequencer #(
    parameter logic [3:0] HALT_OPCODE = 4'hF,
    parameter int         ACK_TIMEOUT = 15,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
`ifdef REDUX_SEQ_STEP_EN
    input  logic             step,
`endif
    input  logic [3:0]       opcode,
    input  logic             ctl_we,
    input  logic             ctl_ld,
    input  logic             ctl_re,
    redux_sequencer_if.master bus,
    output logic             reg_we,
    output logic             pc_en,
    output logic             busy,
    output logic             halted,
    output logic             bus_error,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;
    localparam logic [2:0] ST_FAULT  = 3'd7;

    // The wait counter only ever reaches ACK_TIMEOUT-1 before FAULT is taken.
    localparam int                WAIT_W       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int                TIMEOUT_LAST = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;
    localparam logic [WAIT_W-1:0] WAIT_LAST    = WAIT_W'(TIMEOUT_LAST);
    localparam logic              TIMEOUT_EN   = (ACK_TIMEOUT > 0);

    logic [2:0]        state_reg, state_next;
    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic [CNT_W-1:0]  retired_reg;
    logic              bus_error_reg;
    logic              start_req;
    logic              timeout_hit;

`ifdef REDUX_SEQ_STEP_EN
    assign start_req = run | step;
`else
    assign start_req = run;
`endif

    assign timeout_hit = TIMEOUT_EN && (wait_reg == WAIT_LAST);

    always_comb begin
        state_next = state_reg;
        wait_next  = '0;
        case (state_reg)
            ST_IDLE:   if (start_req) state_next = ST_FETCH;
            ST_FETCH: begin
                // An ack in the final allowed cycle still wins over the timeout.
                if (bus.imem_ack)     state_next = ST_DECODE;
                else if (timeout_hit) state_next = ST_FAULT;
                else                  wait_next  = wait_reg + 1'b1;
            end
            ST_DECODE: state_next = (opcode == HALT_OPCODE) ? ST_HALT : ST_EXEC;
            ST_EXEC:   state_next = (ctl_we | ctl_ld) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (bus.dmem_ack)     state_next = ST_WB;
                else if (timeout_hit) state_next = ST_FAULT;
                else                  wait_next  = wait_reg + 1'b1;
            end
            ST_WB:     state_next = run ? ST_FETCH : ST_IDLE;
            default:   state_next = state_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            wait_reg      <= '0;
            retired_reg   <= '0;
            bus_error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            if (state_reg == ST_WB)
                retired_reg <= retired_reg + 1'b1;
            if (state_next == ST_FAULT)
                bus_error_reg <= 1'b1;
        end
    end

    // All strobes decode from the current state, so HALT/FAULT/IDLE force them low.
    assign bus.imem_req = (state_reg == ST_FETCH);
    assign bus.ir_en    = (state_reg == ST_FETCH) & bus.imem_ack;
    assign bus.dmem_req = (state_reg == ST_MEM);
    assign bus.dmem_we  = (state_reg == ST_MEM) & ctl_we;
    assign pc_en        = (state_reg == ST_WB);
    assign reg_we       = (state_reg == ST_WB) & ctl_re;
    assign busy         = (state_reg != ST_IDLE) && (state_reg != ST_HALT) && (state_reg != ST_FAULT);
    assign halted       = (state_reg == ST_HALT);
    assign bus_error    = bus_error_reg;
    assign state        = state_reg;
    assign retired      = retired_reg;
endmodule

// File: tb/tb_redux_sequencer.sv
// Scoreboard bench for redux_sequencer: the driver queues expected write-back records,
// a monitor pops one per pc_en strobe; memories ack after a programmable number of req cycles.
module tb_redux_sequencer;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_HALT  = 3'd6;
    localparam logic [2:0] S_FAULT = 3'd7;

    logic        clk, rst, run;
`ifdef REDUX_SEQ_STEP_EN
    logic        step;
`endif
    logic [3:0]  opcode;
    logic        ctl_we, ctl_ld, ctl_re;
    logic        reg_we, pc_en, busy, halted, bus_error;
    logic [2:0]  state;
    logic [15:0] retired;

    redux_sequencer_if bus();

    redux_sequencer dut (
        .clk(clk), .rst(rst), .run(run),
`ifdef REDUX_SEQ_STEP_EN
        .step(step),
`endif
        .opcode(opcode), .ctl_we(ctl_we), .ctl_ld(ctl_ld), .ctl_re(ctl_re),
        .bus(bus),
        .reg_we(reg_we), .pc_en(pc_en), .busy(busy), .halted(halted),
        .bus_error(bus_error), .state(state), .retired(retired)
    );

    typedef struct {
        int lat;    // FETCH entry to WB, in cycles
        int re;
        int ret;    // retired value seen during WB
        int dreq;   // dmem_req cycles in this instruction
        int dwe;    // dmem_we cycles in this instruction
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   imem_lat = 1;
    int   dmem_lat = 1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: sim time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    // Memory models: ack in the Nth consecutive req cycle; lat 0 never acks.
    initial begin
        int icnt, dcnt;
        icnt = 0;
        dcnt = 0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.imem_req) begin
                icnt++;
                bus.imem_ack = (imem_lat != 0) && (icnt == imem_lat);
            end else begin
                icnt = 0;
                bus.imem_ack = 1'b0;
            end
            if (bus.dmem_req) begin
                dcnt++;
                bus.dmem_ack = (dmem_lat != 0) && (dcnt == dmem_lat);
            end else begin
                dcnt = 0;
                bus.dmem_ack = 1'b0;
            end
        end
    end

    // Monitor: one scoreboard pop per write-back strobe.
    initial begin
        logic [2:0] prev_state;
        int fetch_start, dreq_cnt, dwe_cnt;
        exp_t e;
        prev_state = S_IDLE;
        fetch_start = 0;
        dreq_cnt = 0;
        dwe_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_state = S_IDLE;
                dreq_cnt = 0;
                dwe_cnt = 0;
            end else begin
                if (state == S_FETCH && prev_state != S_FETCH)
                    fetch_start = cyc;
                if (bus.dmem_req) dreq_cnt++;
                if (bus.dmem_req && bus.dmem_we) dwe_cnt++;
                if (pc_en) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pc_en: got pc_en=1, expected no write-back (cycle %0d)", cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("wb_latency", cyc - fetch_start + 1, e.lat);
                        chk("wb_reg_we", int'(reg_we), e.re);
                        chk("wb_retired", int'(retired), e.ret);
                        chk("wb_dmem_req_cycles", dreq_cnt, e.dreq);
                        chk("wb_dmem_we_cycles", dwe_cnt, e.dwe);
                    end
                    dreq_cnt = 0;
                    dwe_cnt = 0;
                end
                prev_state = state;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic set_instr(input logic [3:0] op, input logic we, input logic ld, input logic re);
        opcode = op;
        ctl_we = we;
        ctl_ld = ld;
        ctl_re = re;
    endtask

    task automatic push(input int lat, input int re, input int ret, input int dreq, input int dwe);
        exp_t e;
        e.lat = lat; e.re = re; e.ret = ret; e.dreq = dreq; e.dwe = dwe;
        sb.push_back(e);
    endtask

    task automatic run_pulse();
        run = 1'b1;
        tick(1);
        run = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int bound, input string name);
        int n = 0;
        while (state != s && n < bound) begin
            tick(1);
            n++;
        end
        chk(name, int'(state), int'(s));
    endtask

    initial begin
        int n, cnt;
        rst = 1'b1;
        run = 1'b0;
`ifdef REDUX_SEQ_STEP_EN
        step = 1'b0;
`endif
        set_instr(4'h0, 1'b0, 1'b0, 1'b0);
        tick(3);
        rst = 1'b0;
        tick(1);

        chk("reset_state", int'(state), 0);
        chk("reset_imem_req", int'(bus.imem_req), 0);
        chk("reset_pc_en", int'(pc_en), 0);
        chk("reset_retired", int'(retired), 0);
        chk("reset_busy", int'(busy), 0);

        // ALU op, zero-wait fetch: WB in cycle 4
        set_instr(4'h1, 1'b0, 1'b0, 1'b1);
        imem_lat = 1;
        push(4, 1, 0, 0, 0);
        run_pulse();
        wait_state(S_IDLE, 30, "alu_back_to_idle");
        chk("alu_retired", int'(retired), 1);

        // Load, dmem ack in third req cycle: WB in cycle 7
        set_instr(4'h2, 1'b0, 1'b1, 1'b1);
        dmem_lat = 3;
        push(7, 1, 1, 3, 0);
        run_pulse();
        wait_state(S_IDLE, 30, "load_back_to_idle");

        // Store: dmem_we during MEM, no register write
        set_instr(4'h3, 1'b1, 1'b0, 1'b0);
        dmem_lat = 1;
        push(5, 0, 2, 1, 1);
        run_pulse();
        wait_state(S_IDLE, 30, "store_back_to_idle");

        // Two ALU ops back to back with run held, then run dropped mid-instruction
        set_instr(4'h4, 1'b0, 1'b0, 1'b0);
        push(4, 0, 3, 0, 0);
        push(4, 0, 4, 0, 0);
        run = 1'b1;
        n = 0;
        while (!pc_en && n < 30) begin
            tick(1);
            n++;
        end
        chk("b2b_first_wb_seen", int'(pc_en), 1);
        tick(1);
        run = 1'b0;
        wait_state(S_IDLE, 30, "b2b_back_to_idle");
        chk("b2b_retired", int'(retired), 5);

        // HALT opcode: terminal, no write-back, retired unchanged
        set_instr(4'hF, 1'b0, 1'b0, 1'b1);
        run_pulse();
        wait_state(S_HALT, 20, "halt_state");
        chk("halt_halted", int'(halted), 1);
        chk("halt_busy", int'(busy), 0);
        tick(5);
        chk("halt_sticky", int'(state), int'(S_HALT));
        chk("halt_retired", int'(retired), 5);

        // Fetch ack on 15th wait cycle: still proceeds to DECODE
        do_reset();
        set_instr(4'h1, 1'b0, 1'b0, 1'b1);
        imem_lat = 15;
        push(18, 1, 0, 0, 0);
        run_pulse();
        wait_state(S_IDLE, 40, "late_ack_back_to_idle");
        chk("late_ack_bus_error", int'(bus_error), 0);

        // No fetch ack: FAULT after 15 request cycles
        imem_lat = 0;
        run_pulse();
        n = 0;
        cnt = 0;
        while (state != S_FAULT && n < 40) begin
            if (bus.imem_req) cnt++;
            tick(1);
            n++;
        end
        chk("fault_state", int'(state), int'(S_FAULT));
        chk("fault_req_cycles", cnt, 15);
        chk("fault_bus_error", int'(bus_error), 1);
        chk("fault_busy", int'(busy), 0);

        // Reset in the MEM cycle that carries the ack
        do_reset();
        chk("post_reset_bus_error", int'(bus_error), 0);
        imem_lat = 1;
        dmem_lat = 3;
        set_instr(4'h2, 1'b0, 1'b1, 1'b1);
        run_pulse();
        n = 0;
        while (!bus.dmem_req && n < 20) begin
            tick(1);
            n++;
        end
        chk("rstmem_in_mem", int'(bus.dmem_req), 1);
        tick(2);
        rst = 1'b1;
        tick(1);
        chk("rstmem_state", int'(state), 0);
        chk("rstmem_dmem_req", int'(bus.dmem_req), 0);
        chk("rstmem_pc_en", int'(pc_en), 0);
        chk("rstmem_retired", int'(retired), 0);
        rst = 1'b0;
        tick(3);
        chk("rstmem_stays_idle", int'(state), 0);

`ifdef REDUX_SEQ_STEP_EN
        // Single step with run low: one instruction then IDLE
        set_instr(4'h1, 1'b0, 1'b0, 1'b1);
        push(4, 1, 0, 0, 0);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        wait_state(S_IDLE, 30, "step_back_to_idle");
        tick(3);
        chk("step_retired", int'(retired), 1);
        chk("step_still_idle", int'(state), 0);
`endif

        tick(2);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
